// File: rtl/mxint_accumulator.sv
// -----------------------------------------------------------------------------
// mxint_accumulator
//
// Reduces a stream of MXINT scalar partial sums (signed mantissa + shared
// biased exponent) into one MXINT result every BLOCK_NUM accepted beats.
// Before each addition the running sum and the incoming term are aligned to
// the larger of the two exponents by an arithmetic right shift of the
// operand with the smaller exponent.
//
// Optional feature (compile-time macro MXINT_ACCUMULATOR_ROUND_EN):
//   defined   : alignment shifts round half-up, (x + 2^(d-1)) >>> d
//   undefined : alignment shifts truncate toward negative infinity (>>>)
//
// Ports:
//   clk               in   rising-edge clock
//   rst               in   synchronous active-high reset
//   mdata_in_0        in   signed partial-sum mantissa
//   edata_in_0        in   biased exponent of mdata_in_0
//   data_in_0_valid   in   input beat valid
//   data_in_0_ready   out  input beat accepted when valid & ready
//   mdata_out_0       out  signed accumulated mantissa
//   edata_out_0       out  biased exponent of the result
//   data_out_0_valid  out  result valid (held with stable data until ready)
//   data_out_0_ready  in   downstream accepts the result
// -----------------------------------------------------------------------------
module mxint_accumulator #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int BLOCK_NUM              = 4,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + $clog2(BLOCK_NUM),
    parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0]  mdata_in_0,
    input  logic        [DATA_IN_0_PRECISION_1-1:0]  edata_in_0,
    input  logic                                     data_in_0_valid,
    output logic                                     data_in_0_ready,
    output logic signed [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0,
    output logic        [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
    output logic                                     data_out_0_valid,
    input  logic                                     data_out_0_ready
);

    localparam int MW = DATA_OUT_0_PRECISION_0;
    localparam int EI = DATA_IN_0_PRECISION_1;
    localparam int EO = DATA_OUT_0_PRECISION_1;
    // A counter is kept even for BLOCK_NUM==1 so the width is never zero.
    localparam int CW = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_NUM - 1);

    // Arithmetic alignment shift of an accumulator-width operand by d.
    // Shift distances at or beyond the operand width collapse to the sign
    // fill (truncating) or to zero (rounding), matching what an unbounded
    // shifter would produce.
    function automatic logic signed [MW-1:0] align_shift(
        input logic signed [MW-1:0] x,
        input logic        [EI-1:0] d
    );
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        logic signed [MW:0] g;
        if (d == '0) begin
            return x;
        end
        if (int'(d) >= MW) begin
            return '0;
        end
        // One guard bit keeps x + 2^(d-1) from overflowing before the shift.
        g = $signed((MW+1)'(x)) + $signed((MW+1)'(1) << (d - EI'(1)));
        return MW'(g >>> d);
`else
        if (int'(d) >= MW) begin
            return {MW{x[MW-1]}};
        end
        return x >>> d;
`endif
    endfunction

    logic [CW-1:0]          cnt;
    logic signed [MW-1:0]   acc_m;
    logic        [EI-1:0]   acc_e;

    logic signed [MW-1:0]   in_ext;
    logic                   in_larger;
    logic        [EI-1:0]   d;
    logic signed [MW-1:0]   sum_m;
    logic        [EI-1:0]   sum_e;
    logic                   in_fire;
    logic                   out_fire;

    // Stall only while a finished result is waiting to be taken.
    assign data_in_0_ready = !data_out_0_valid || data_out_0_ready;
    assign in_fire         = data_in_0_valid && data_in_0_ready;
    assign out_fire        = data_out_0_valid && data_out_0_ready;

    // Sign extension to the accumulator width (wraps if the output width is
    // overridden narrower than the input).
    assign in_ext    = MW'(mdata_in_0);
    assign in_larger = edata_in_0 > acc_e;
    assign d         = in_larger ? (edata_in_0 - acc_e) : (acc_e - edata_in_0);

    // Next accumulator value for the beat currently at the input.
    // NOTE: every variable gets a default at the top of always_comb, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        sum_m = in_ext;
        sum_e = edata_in_0;
        if (cnt != '0) begin
            if (in_larger) begin
                sum_m = align_shift(acc_m, d) + in_ext;
                sum_e = edata_in_0;
            end else begin
                sum_m = acc_m + align_shift(in_ext, d);
                sum_e = acc_e;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            acc_m            <= '0;
            acc_e            <= '0;
            mdata_out_0      <= '0;
            edata_out_0      <= '0;
            data_out_0_valid <= 1'b0;
        end else begin
            // Consumption first; a last beat in the same cycle re-arms valid
            // below, so the later assignment wins and throughput is kept.
            if (out_fire) begin
                data_out_0_valid <= 1'b0;
            end
            if (in_fire) begin
                acc_m <= sum_m;
                acc_e <= sum_e;
                if (cnt == LAST) begin
                    cnt              <= '0;
                    mdata_out_0      <= sum_m;
                    edata_out_0      <= EO'(sum_e);
                    data_out_0_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mxint_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mxint_accumulator
//
// Two accumulator instances (BLOCK_NUM=4 and BLOCK_NUM=2) driven by directed
// beats. Expected results are hand-computed and pushed into a per-instance
// queue; a monitor per instance pops and compares whenever a result is
// handed off (valid & ready sampled on the falling edge).
// -----------------------------------------------------------------------------
module tb_mxint_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // BLOCK_NUM=4 instance (output mantissa 10 bits)
    logic signed [7:0] mi4 = '0;
    logic        [7:0] ei4 = '0;
    logic              vi4 = 1'b0;
    logic              ri4;
    logic signed [9:0] mo4;
    logic        [7:0] eo4;
    logic              vo4;
    logic              ro4 = 1'b1;

    // BLOCK_NUM=2 instance (output mantissa 9 bits)
    logic signed [7:0] mi2 = '0;
    logic        [7:0] ei2 = '0;
    logic              vi2 = 1'b0;
    logic              ri2;
    logic signed [8:0] mo2;
    logic        [7:0] eo2;
    logic              vo2;
    logic              ro2 = 1'b1;

    int exp_m4[$];
    int exp_e4[$];
    int exp_m2[$];
    int exp_e2[$];

    mxint_accumulator #(.BLOCK_NUM(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (mi4),
        .edata_in_0       (ei4),
        .data_in_0_valid  (vi4),
        .data_in_0_ready  (ri4),
        .mdata_out_0      (mo4),
        .edata_out_0      (eo4),
        .data_out_0_valid (vo4),
        .data_out_0_ready (ro4)
    );

    mxint_accumulator #(.BLOCK_NUM(2)) u_dut2 (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (mi2),
        .edata_in_0       (ei2),
        .data_in_0_valid  (vi2),
        .data_in_0_ready  (ri2),
        .mdata_out_0      (mo2),
        .edata_out_0      (eo2),
        .data_out_0_valid (vo2),
        .data_out_0_ready (ro2)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one beat and wait (bounded) for its handshake; returns the
    // number of cycles the beat was presented.
    task automatic send(input int which, input int m, input int e, output int cycles);
        logic ok;
        if (which == 4) begin
            mi4 = 8'(m); ei4 = 8'(e); vi4 = 1'b1;
        end else begin
            mi2 = 8'(m); ei2 = 8'(e); vi2 = 1'b1;
        end
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < 50) begin
            @(negedge clk);
            ok = (which == 4) ? ri4 : ri2;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (which == 4) vi4 = 1'b0; else vi2 = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: dut%0d beat (%0d,%0d) not accepted in 50 cycles", which, m, e);
        end
    endtask

    task automatic expect4(input int m, input int e);
        exp_m4.push_back(m);
        exp_e4.push_back(e);
    endtask

    task automatic expect2(input int m, input int e);
        exp_m2.push_back(m);
        exp_e2.push_back(e);
    endtask

    // Monitors: one comparison per result handed downstream.
    always @(negedge clk) begin
        if (!rst && vo4 && ro4) begin
            if (exp_m4.size() == 0) begin
                check("dut4_unexpected_result", int'(mo4), 99999);
            end else begin
                check("dut4_result_m", int'(mo4), exp_m4.pop_front());
                check("dut4_result_e", int'(eo4), exp_e4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vo2 && ro2) begin
            if (exp_m2.size() == 0) begin
                check("dut2_unexpected_result", int'(mo2), 99999);
            end else begin
                check("dut2_result_m", int'(mo2), exp_m2.pop_front());
                check("dut2_result_e", int'(eo2), exp_e2.pop_front());
            end
        end
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid4", int'(vo4), 0);
        check("reset_m4", int'(mo4), 0);
        check("reset_e4", int'(eo4), 0);
        check("reset_valid2", int'(vo2), 0);
        check("reset_m2", int'(mo2), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Equal exponents, back-to-back; 1-cycle latency after last beat.
        expect4(100, 127);
        send(4, 10, 127, n);
        send(4, 20, 127, n);
        send(4, 30, 127, n);
        send(4, 40, 127, n);
        check("latency_valid4", int'(vo4), 1);

        // Most negative sum fills the full output width.
        expect4(-512, 127);
        for (int i = 0; i < 4; i++) send(4, -128, 127, n);

        // Alignment in both directions.
        expect2(24, 128);
        send(2, 16, 127, n);
        send(2, 16, 128, n);
        expect2(24, 128);
        send(2, 16, 128, n);
        send(2, 16, 127, n);

`ifdef MXINT_ACCUMULATOR_ROUND_EN
        expect2(-4, 128);
`else
        expect2(-5, 128);
`endif
        send(2, -3, 128, n);
        send(2, -3, 127, n);

        // Shift distance far beyond the output width.
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        expect2(5, 127);
`else
        expect2(4, 127);
`endif
        send(2, 5, 127, n);
        send(2, -7, 20, n);

        // Shift distance exactly equal to the output width (9).
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        expect2(5, 127);
`else
        expect2(4, 127);
`endif
        send(2, 5, 127, n);
        send(2, -7, 118, n);

        // d=3, incoming exponent smaller: 12>>>3 = 1, rounded = 2.
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        expect2(-6, 130);
`else
        expect2(-7, 130);
`endif
        send(2, -8, 130, n);
        send(2, 12, 127, n);

        // Backpressure: result held, input stalled.
        ro4 = 1'b0;
        expect4(10, 127);
        send(4, 1, 127, n);
        send(4, 2, 127, n);
        send(4, 3, 127, n);
        send(4, 4, 127, n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(ri4), 0);
            check("bp_valid", int'(vo4), 1);
            check("bp_hold_m", int'(mo4), 10);
            check("bp_hold_e", int'(eo4), 127);
        end
        @(posedge clk);
        #1;
        // Ready rises together with the first beat of the next group:
        // -5@127, 3@129 (d=2), 8@128 (d=1), -1@129 (d=0).
        ro4 = 1'b1;
`ifdef MXINT_ACCUMULATOR_ROUND_EN
        expect4(5, 129);
`else
        expect4(4, 129);
`endif
        send(4, -5, 127, n);
        check("simultaneous_handshake_cycles", n, 1);
        send(4, 3, 129, n);
        send(4, 8, 128, n);
        send(4, -1, 129, n);

        // Reset mid-accumulation discards the partial sum.
        send(4, 7, 127, n);
        send(4, 9, 127, n);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_valid4", int'(vo4), 0);
        check("midreset_m4", int'(mo4), 0);
        check("midreset_e4", int'(eo4), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect4(4, 127);
        for (int i = 0; i < 4; i++) send(4, 1, 127, n);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("dut4_pending_results", exp_m4.size(), 0);
        check("dut2_pending_results", exp_m2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mxint_accumulator.md
Name: mxint_accumulator

Overview:
- Downstream consumer of the MXINT dot-product stage.
- Takes a stream of scalar partial sums, each a signed mantissa with a shared biased exponent, and accumulates BLOCK_NUM consecutive beats into one MXINT result.
- Before each addition, aligns the running sum and the incoming term to the larger exponent.
- Used to reduce partial dot products across blocks of a wide linear layer before output quantisation.

Parameters:
- DATA_IN_0_PRECISION_0, 8: input mantissa width (signed two's complement).
- DATA_IN_0_PRECISION_1, 8: input exponent width (unsigned, biased).
- BLOCK_NUM, 4: beats accumulated per output; must be >= 1.
- DATA_OUT_0_PRECISION_0, DATA_IN_0_PRECISION_0 + $clog2(BLOCK_NUM): output mantissa width.
- DATA_OUT_0_PRECISION_1, DATA_IN_0_PRECISION_1: output exponent width. Same bias as the input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mdata_in_0  input  DATA_IN_0_PRECISION_0  signed partial-sum mantissa.
- edata_in_0  input  DATA_IN_0_PRECISION_1  biased exponent of mdata_in_0.
- data_in_0_valid  input  1  input beat valid.
- data_in_0_ready  output  1  input beat accepted when valid & ready.
- mdata_out_0  output  DATA_OUT_0_PRECISION_0  signed accumulated mantissa.
- edata_out_0  output  DATA_OUT_0_PRECISION_1  biased exponent of the result.
- data_out_0_valid  output  1  result valid.
- data_out_0_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything:
  - data_out_0_valid=0; mdata_out_0=0; edata_out_0=0.
  - Beat counter=0; accumulator mantissa and exponent=0.
  - Reset mid-accumulation discards the partial sum.
- State: beat counter cnt in 0..BLOCK_NUM-1, accumulator acc_m (output width) and acc_e, output register.
- Handshake:
  - data_in_0_ready = !data_out_0_valid | data_out_0_ready. The block stalls only while an unconsumed result is held.
  - data_out_0_valid holds, with stable data, until data_out_0_ready=1.
- Accepted beat with cnt==0: acc_m <= sign-extend(mdata_in_0), acc_e <= edata_in_0. No alignment.
- Accepted beat with cnt>0, where d = |edata_in_0 - acc_e| (unsigned compare):
  - If edata_in_0 > acc_e: acc_m <= (acc_m >>> d) + ext(mdata_in_0), acc_e <= edata_in_0.
  - Otherwise: acc_m <= acc_m + (ext(mdata_in_0) >>> d), acc_e unchanged.
  - Shifts are arithmetic.
  - If d >= DATA_OUT_0_PRECISION_0, the shifted operand becomes its sign fill: 0 or -1, or per rounding when the optional feature is enabled.
- Counter: increments per accepted beat and wraps to 0 after BLOCK_NUM-1.
- On the accepted beat with cnt==BLOCK_NUM-1:
  - The combined result is written directly to mdata_out_0/edata_out_0 and data_out_0_valid is set next cycle.
  - Latency is 1 cycle from the last input handshake.
  - Accumulator state is not needed afterwards; the next beat is treated as cnt==0.
- BLOCK_NUM==1: every accepted beat is passed to the output register with 1-cycle latency.
- Simultaneous output handshake and input beat: both take effect in the same cycle.
  - The held result is consumed.
  - The new beat either starts a new accumulation or, if it is the last beat, replaces the output register and valid stays 1.
  - Full throughput of one beat per cycle is sustained.
- Arithmetic: no overflow is possible at default widths because right shifts only shrink magnitude. Sums wrap modulo 2^DATA_OUT_0_PRECISION_0 if a user overrides the width smaller.
- Exponents never overflow; the result exponent is always one of the input exponents.

Optional Feature:
- Macro: MXINT_ACCUMULATOR_ROUND_EN.
- Defined: every alignment shift with d>0 rounds half-up. Shifted value = (x + 2^(d-1)) >>> d, computed with one guard bit so no overflow occurs. For d >= DATA_OUT_0_PRECISION_0 the result is 0.
- Undefined: truncation toward negative infinity (plain >>>).

Test Plan:
- BLOCK_NUM=4, beats (10,127),(20,127),(30,127),(40,127) back-to-back, data_out_0_ready=1 → one cycle after the 4th handshake: valid=1, mdata_out_0=100, edata_out_0=127.
- BLOCK_NUM=2, beats (16,127),(16,128) → mdata_out_0=24, edata_out_0=128. Beats (16,128),(16,127) → also 24, 128.
- BLOCK_NUM=2, beats (-3,128),(-3,127):
  - Without macro: out=-5 (since -3>>>1 = -2).
  - With MXINT_ACCUMULATOR_ROUND_EN: out=-4.
- BLOCK_NUM=2, beats (5,127),(-7,20), where d exceeds the output width → out=4 without the macro (the -7 becomes -1), out=5 with the macro; edata_out_0=127.
- Backpressure:
  - Hold data_out_0_ready=0 after a result → data_in_0_ready=0 and output stable for 5 cycles.
  - Raise ready together with a valid first beat of the next group → both handshakes complete in the same cycle; the next result is correct.
- Assert rst after 2 of 4 beats, then send 4 fresh beats of (1,127) → outputs zero during reset; the following result is 4 at exponent 127 with no residue from the earlier beats.
